hls_start_done_driver: RTL
==========================

# hls_start_done_driver

Initiator for the Start/Done handshake used by the team's HLS-generated HLSM modules. It accepts one operand set (a–e) over a valid/ready input port, drives the operand buses, and issues a one-cycle Start pulse. It then waits for Done, captures result i and the measured latency, and returns them over a valid/ready output port. It sits between a stimulus or host source and one HLSM instance, for on-chip latency checking of scheduled designs.

## Interface
- DATA_WIDTH, 16, width of each signed operand and of the result
- CNT_WIDTH, 8, width of the latency counter and of res_cycles
- TIMEOUT, 64, WAIT cycles without Done before abort (used only with the configuration macro enabled)

Ports:
- Clk  in  1  clock; all logic on the rising edge
- Rst  in  1  synchronous, active-high reset
- op_valid  in  1  operand set offered
- op_ready  out  1  driver accepts operand set
- op_a, op_b, op_c, op_d, op_e  in  DATA_WIDTH each  signed operands
- Start  out  1  one-cycle launch pulse to the HLSM
- Done  in  1  completion from the HLSM
- a, b, c, d, e  out  DATA_WIDTH each  signed operand buses to the HLSM
- i  in  DATA_WIDTH  signed result from the HLSM
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_data  out  DATA_WIDTH  captured i
- res_cycles  out  CNT_WIDTH  measured Start-to-Done latency
- res_timeout  out  1  result was aborted by timeout
- spurious_done  out  1  sticky flag: Done seen while no launch was outstanding

## Operation
- States: IDLE, LAUNCH, WAIT, RESULT.
- IDLE:
  - op_ready=1.
  - On op_valid&&op_ready, register op_a..op_e into a..e and go to LAUNCH.
- LAUNCH (exactly one cycle):
  - Start=1; counter loaded with 1; go to WAIT.
  - Done is not sampled in this cycle.
- WAIT:
  - Start=0; a..e held stable.
  - If Done=1: capture i into res_data and the counter into res_cycles; res_timeout=0; go to RESULT.
  - Otherwise the counter increments, saturating at its maximum.
- RESULT:
  - res_valid=1; res_data, res_cycles and res_timeout held stable.
  - On res_ready go to IDLE.
  - op_ready=0, so there is one idle cycle between transactions.
- Done=1 in IDLE, LAUNCH or RESULT sets spurious_done. The flag clears only on Rst and never alters state.
- Reset values: state IDLE; Start, res_valid, res_timeout and spurious_done 0; a..e, res_data and res_cycles 0.
- Reset mid-transaction:
  - Abandons the transaction; no result is emitted.
  - Any Done still in flight from the HLSM after reset counts as spurious.
- Arithmetic:
  - Operands and result are passed through unmodified, signed, with no width change.
  - The counter is unsigned CNT_WIDTH and saturates at 2^CNT_WIDTH−1.

## Timing
- Operand handshake at edge N: LAUNCH in cycle N+1 (Start high); WAIT from N+2.
- res_cycles is the number of cycles from the Start-high cycle to the Done-high cycle. Example: for an HLSM with LATENCY=4, Done arrives 4 cycles after Start, so res_cycles=4.
- res_valid rises the cycle after Done is sampled.
- Minimum transaction length, op handshake to res handshake with res_ready held at 1: latency+3 cycles.
- Done is a level sample per cycle. Only the first Done cycle in WAIT completes the transaction; Done held high into RESULT sets spurious_done.

## Configuration
- Macro: HLS_DRV_TIMEOUT_EN.
- Defined:
  - In WAIT, when the counter reaches TIMEOUT with no Done, go to RESULT with res_timeout=1, res_data=0, res_cycles=TIMEOUT.
  - If Done and the timeout coincide in the same cycle, Done wins.
- Undefined:
  - WAIT waits indefinitely; res_timeout is tied to 0.
  - The TIMEOUT parameter is ignored.

## Structure
- Package hls_drv_pkg holds:
  - the state enum (IDLE, LAUNCH, WAIT, RESULT);
  - default DATA_WIDTH and CNT_WIDTH constants;
  - the default TIMEOUT constant.
- One sub-module, hls_drv_lat_counter:
  - a load-1 / increment / saturate counter;
  - the timeout compare, present only when HLS_DRV_TIMEOUT_EN is defined.
- The FSM, operand registers and result registers live in the top module.

## Test plan
- Against an HLSM of LATENCY=4 (chained adds), send a=1, b=2, c=3, d=4, e=5 with res_ready=1 -> one Start pulse; res_data=15, res_cycles=4, res_timeout=0.
- Two back-to-back sets (−100, 50, 25, 10, 5) and (0x7FFF, 1, 0, 0, 0) -> res_data=−10, then 0x8000 (wraps). op_ready stays 0 from acceptance until the res handshake, and a..e never change during WAIT.
- Hold res_ready=0 for 10 cycles after Done -> res_valid and res_data stay stable; op_ready stays 0; the transaction completes on the first res_ready cycle.
- With HLS_DRV_TIMEOUT_EN and TIMEOUT=8, Done tied low -> RESULT after 8 WAIT cycles with res_timeout=1, res_data=0, res_cycles=8. In a separate run with Done arriving exactly at the timeout cycle -> res_timeout=0.
- Pulse Done in IDLE -> spurious_done=1 and stays 1 through a following normal transaction, which completes correctly.
- Assert Rst during WAIT -> next cycle: IDLE, Start=0, res_valid=0, all outputs 0. The late Done sets spurious_done, and no result is emitted.

Source files
------------

// File: rtl/hls_drv_pkg.sv
// Shared types and default sizes for the HLS Start/Done driver.
// Optional feature macro: HLS_DRV_TIMEOUT_EN (WAIT-state timeout abort).
package hls_drv_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 16;
   localparam int unsigned DEF_CNT_WIDTH  = 8;
   localparam int unsigned DEF_TIMEOUT    = 64;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StLaunch = 2'd1,
      StWait   = 2'd2,
      StResult = 2'd3
   } drv_state_e;

endpackage

// File: rtl/hls_start_done_driver_if.sv
// Operand, Start/Done and result signals between the driver and its environment.
// master: the driver; slave: host source, HLSM and result consumer seen as one.
// Optional feature macro: HLS_DRV_TIMEOUT_EN (affects only res_timeout behaviour).
interface hls_start_done_driver_if import hls_drv_pkg::*; #(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) ();

   // operand port
   logic                         op_valid;
   logic                         op_ready;
   logic signed [DATA_WIDTH-1:0] op_a;
   logic signed [DATA_WIDTH-1:0] op_b;
   logic signed [DATA_WIDTH-1:0] op_c;
   logic signed [DATA_WIDTH-1:0] op_d;
   logic signed [DATA_WIDTH-1:0] op_e;

   // HLSM side
   logic                         Start;
   logic                         Done;
   logic signed [DATA_WIDTH-1:0] a;
   logic signed [DATA_WIDTH-1:0] b;
   logic signed [DATA_WIDTH-1:0] c;
   logic signed [DATA_WIDTH-1:0] d;
   logic signed [DATA_WIDTH-1:0] e;
   logic signed [DATA_WIDTH-1:0] i;

   // result port
   logic                         res_valid;
   logic                         res_ready;
   logic signed [DATA_WIDTH-1:0] res_data;
   logic [CNT_WIDTH-1:0]         res_cycles;
   logic                         res_timeout;
   logic                         spurious_done;

   modport master (
      input  op_valid, op_a, op_b, op_c, op_d, op_e, Done, i, res_ready,
      output op_ready, Start, a, b, c, d, e,
             res_valid, res_data, res_cycles, res_timeout, spurious_done
   );

   modport slave (
      output op_valid, op_a, op_b, op_c, op_d, op_e, Done, i, res_ready,
      input  op_ready, Start, a, b, c, d, e,
             res_valid, res_data, res_cycles, res_timeout, spurious_done
   );

endinterface

// File: rtl/hls_drv_lat_counter.sv
// Start-to-Done latency counter: load 1, increment, saturate at all-ones.
// Optional feature macro: HLS_DRV_TIMEOUT_EN adds the timeout compare output.
module hls_drv_lat_counter import hls_drv_pkg::*; #(
   parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH,
   parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 load,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] count
`ifdef HLS_DRV_TIMEOUT_EN
   ,
   output logic                 timeout_hit
`endif
);

   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;

   // Next count: load wins over increment; hold once saturated
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = CNT_WIDTH'(1);
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   // Counter register
   always_ff @(posedge Clk) begin
      if (Rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;

`ifdef HLS_DRV_TIMEOUT_EN
   assign timeout_hit = (cnt_q == CNT_WIDTH'(TIMEOUT));
`else
   // TIMEOUT has no effect without the timeout feature
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
`endif

endmodule

// File: rtl/hls_start_done_driver.sv
// Start/Done handshake initiator for HLS-generated HLSM modules: takes one operand
// set, pulses Start, waits for Done, returns result i plus measured latency.
// Optional feature macro: HLS_DRV_TIMEOUT_EN (abort WAIT after TIMEOUT cycles).
module hls_start_done_driver import hls_drv_pkg::*; #(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH,
   parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
   input logic                      Clk,
   input logic                      Rst,
   hls_start_done_driver_if.master  bus
);

   drv_state_e state_q;
   drv_state_e state_d;

   logic signed [DATA_WIDTH-1:0] a_q, b_q, c_q, d_q, e_q;
   logic signed [DATA_WIDTH-1:0] res_data_q;
   logic [CNT_WIDTH-1:0]         res_cycles_q;
   logic                         spurious_q;
   logic [CNT_WIDTH-1:0]         count;
   logic                         cnt_load;
   logic                         cnt_inc;
`ifdef HLS_DRV_TIMEOUT_EN
   logic                         timeout_hit;
   logic                         res_timeout_q;
`endif

   hls_drv_lat_counter #(
      .CNT_WIDTH (CNT_WIDTH),
      .TIMEOUT   (TIMEOUT)
   ) u_lat_counter (
      .Clk         (Clk),
      .Rst         (Rst),
      .load        (cnt_load),
      .inc         (cnt_inc),
      .count       (count)
`ifdef HLS_DRV_TIMEOUT_EN
      ,
      .timeout_hit (timeout_hit)
`endif
   );

   // FSM state register
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; Done outside WAIT never changes state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (bus.op_valid) state_d = StLaunch;
         StLaunch: state_d = StWait;
         StWait: begin
            if (bus.Done) begin
               state_d = StResult;
`ifdef HLS_DRV_TIMEOUT_EN
            end else if (timeout_hit) begin
               state_d = StResult;
`endif
            end
         end
         StResult: if (bus.res_ready) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // FSM outputs, decoded from the current state
   always_comb begin
      bus.op_ready  = (state_q == StIdle);
      bus.Start     = (state_q == StLaunch);
      bus.res_valid = (state_q == StResult);
      cnt_load      = (state_q == StLaunch);
      cnt_inc       = (state_q == StWait);
   end

   // Operand capture on the op handshake; held through LAUNCH, WAIT and RESULT
   always_ff @(posedge Clk) begin
      if (Rst) begin
         a_q <= '0;
         b_q <= '0;
         c_q <= '0;
         d_q <= '0;
         e_q <= '0;
      end else if ((state_q == StIdle) && bus.op_valid) begin
         a_q <= bus.op_a;
         b_q <= bus.op_b;
         c_q <= bus.op_c;
         d_q <= bus.op_d;
         e_q <= bus.op_e;
      end
   end

   // Result capture on the first Done in WAIT; Done beats a coincident timeout
   always_ff @(posedge Clk) begin
      if (Rst) begin
         res_data_q    <= '0;
         res_cycles_q  <= '0;
`ifdef HLS_DRV_TIMEOUT_EN
         res_timeout_q <= 1'b0;
`endif
      end else if (state_q == StWait) begin
         if (bus.Done) begin
            res_data_q    <= bus.i;
            res_cycles_q  <= count;
`ifdef HLS_DRV_TIMEOUT_EN
            res_timeout_q <= 1'b0;
         end else if (timeout_hit) begin
            res_data_q    <= '0;
            res_cycles_q  <= CNT_WIDTH'(TIMEOUT);
            res_timeout_q <= 1'b1;
`endif
         end
      end
   end

   // Sticky flag for Done seen with no launch outstanding (includes post-reset Done)
   always_ff @(posedge Clk) begin
      if (Rst) begin
         spurious_q <= 1'b0;
      end else if (bus.Done && (state_q != StWait)) begin
         spurious_q <= 1'b1;
      end
   end

   assign bus.a             = a_q;
   assign bus.b             = b_q;
   assign bus.c             = c_q;
   assign bus.d             = d_q;
   assign bus.e             = e_q;
   assign bus.res_data      = res_data_q;
   assign bus.res_cycles    = res_cycles_q;
   assign bus.spurious_done = spurious_q;
`ifdef HLS_DRV_TIMEOUT_EN
   assign bus.res_timeout   = res_timeout_q;
`else
   assign bus.res_timeout   = 1'b0;
`endif

endmodule
